// File: rtl/atri_var_trig_decoder.sv
// Variable-length soft trigger decoder: measures trigger pulse width,
// recovers nblk, strobes per block pair and flags malformed pulses.
module atri_var_trig_decoder #(
   parameter int COUNTER_WIDTH = 4,
   parameter int INFO_WIDTH    = 4
) (
   input  logic                     fast_clk_i,
   input  logic                     f_rst_i,
   input  logic                     f_trig_i,
   input  logic                     disable_i,
   input  logic                     f_clr_info_i,
   output logic                     f_busy_o,
   output logic                     f_blk_stb_o,
   output logic [COUNTER_WIDTH-1:0] f_blk_idx_o,
   output logic                     f_valid_o,
   output logic [COUNTER_WIDTH-1:0] f_nblk_o,
   output logic                     f_err_o,
   output logic [1:0]               f_err_code_o,
   output logic [INFO_WIDTH-1:0]    f_info_o
);

   localparam int CW = COUNTER_WIDTH;
   localparam int LW = COUNTER_WIDTH + 2;
   localparam logic [LW-1:0] MAXLEN = LW'(2 ** (CW + 1));
   localparam logic [CW-1:0] ONE_C = CW'(1);
   localparam logic [INFO_WIDTH-1:0] ONE_I = INFO_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      DRAIN,
      DRAIN_ERR
   } state_t;

   state_t                state_q, state_d;
   logic [LW-1:0]         len_q, len_d, len_inc;
   logic                  armed_q;
   logic                  busy_q, busy_d;
   logic                  stb_q, stb_d;
   logic [CW-1:0]         idx_q, idx_d;
   logic                  valid_q, valid_d;
   logic [CW-1:0]         nblk_q, nblk_d;
   logic                  err_q, err_d;
   logic [1:0]            code_q, code_d;
   logic [INFO_WIDTH-1:0] info_q, info_d;

   assign len_inc = len_q + LW'(1);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      stb_d   = 1'b0;
      idx_d   = idx_q;
      valid_d = 1'b0;
      nblk_d  = nblk_q;
      err_d   = 1'b0;
      code_d  = code_q;
      info_d  = info_q;
      unique case (state_q)
         IDLE: begin
            // armed_q is low only in the first cycle after reset, so a
            // pulse already in flight at that point is drained silently
            if (f_trig_i) begin
               if (!armed_q || disable_i) begin
                  state_d = DRAIN;
               end else begin
                  state_d = ACTIVE;
                  len_d   = LW'(1);
               end
            end
         end
         ACTIVE: begin
            if (f_trig_i) begin
               if (len_q == MAXLEN) begin
                  state_d = DRAIN_ERR;
               end else begin
                  len_d = len_inc;
                  if (!len_inc[0]) begin
                     stb_d = 1'b1;
                     idx_d = len_inc[CW:1] - ONE_C;
                  end
               end
            end else begin
               state_d = IDLE;
               if (!len_q[0]) begin
                  valid_d = 1'b1;
                  nblk_d  = len_q[CW:1] - ONE_C;
                  info_d  = info_q + ONE_I;
               end else begin
                  err_d  = 1'b1;
                  code_d = 2'b01;
               end
            end
         end
         DRAIN: begin
            if (!f_trig_i) state_d = IDLE;
         end
         DRAIN_ERR: begin
            if (!f_trig_i) begin
               state_d = IDLE;
               err_d   = 1'b1;
               code_d  = 2'b10;
            end
         end
         default: state_d = IDLE;
      endcase
      if (f_clr_info_i) info_d = '0;
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge fast_clk_i) begin
      if (f_rst_i) begin
         state_q <= IDLE;
         len_q   <= '0;
         armed_q <= 1'b0;
         busy_q  <= 1'b0;
         stb_q   <= 1'b0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         nblk_q  <= '0;
         err_q   <= 1'b0;
         code_q  <= '0;
         info_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         armed_q <= 1'b1;
         busy_q  <= busy_d;
         stb_q   <= stb_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         nblk_q  <= nblk_d;
         err_q   <= err_d;
         code_q  <= code_d;
         info_q  <= info_d;
      end
   end

   assign f_busy_o     = busy_q;
   assign f_blk_stb_o  = stb_q;
   assign f_blk_idx_o  = idx_q;
   assign f_valid_o    = valid_q;
   assign f_nblk_o     = nblk_q;
   assign f_err_o      = err_q;
   assign f_err_code_o = code_q;
   assign f_info_o     = info_q;

endmodule
